// File: rtl/fetch_step_ctrl.sv
// Fetch-enable generator for the instruction fetch unit: debounced single-step or divided free-run,
// plus a wrapping count of issued fetch pulses.

module fetch_step_debounce #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int unsigned DB_W = $clog2(CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(CYCLES);

    logic            sync_1;
    logic            sync_2;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            // Level only moves after the synced input has disagreed for CYCLES straight cycles.
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// state  | meaning
// S_HALT | idle, waiting for a step request or run switch
// S_STEP | issuing the single-step fetch pulse this cycle
// S_RUN  | free-running, pulse every RUN_DIV cycles
module fetch_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RUN_DIV         = 50_000_000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             BtnStep,
    input  logic             SwRun,
    output logic             FetchEn,
    output logic             Running,
    output logic [CNT_W-1:0] StepCount
);

    localparam int unsigned DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic             btn_level;
    logic             btn_level_q;
    logic             run_level;
    logic             step_req;

    fetch_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk   (Clk),
        .rst_n (Reset),
        .raw   (BtnStep),
        .level (btn_level)
    );

    fetch_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk   (Clk),
        .rst_n (Reset),
        .raw   (SwRun),
        .level (run_level)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            btn_level_q <= 1'b0;
        end else begin
            btn_level_q <= btn_level;
        end
    end

    assign step_req = btn_level & ~btn_level_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_HALT;
            div     <= '0;
            FetchEn <= 1'b0;
            Running <= 1'b0;
        end else begin
            case (state)
                S_HALT: begin
                    div <= '0;
                    // Run switch wins; a coincident step request is simply lost.
                    if (run_level) begin
                        state   <= S_RUN;
                        FetchEn <= 1'b0;
                        Running <= 1'b1;
                    end else if (step_req) begin
                        state   <= S_STEP;
                        FetchEn <= 1'b1;
                        Running <= 1'b0;
                    end else begin
                        FetchEn <= 1'b0;
                        Running <= 1'b0;
                    end
                end
                S_STEP: begin
                    state   <= S_HALT;
                    div     <= '0;
                    FetchEn <= 1'b0;
                    Running <= 1'b0;
                end
                S_RUN: begin
                    if (!run_level) begin
                        state   <= S_HALT;
                        div     <= '0;
                        FetchEn <= 1'b0;
                        Running <= 1'b0;
                    end else if (div == DIV_LAST) begin
                        div     <= '0;
                        FetchEn <= 1'b1;
                        Running <= 1'b1;
                    end else begin
                        div     <= div + 1'b1;
                        FetchEn <= 1'b0;
                        Running <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_HALT;
                    div     <= '0;
                    FetchEn <= 1'b0;
                    Running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StepCount <= '0;
        end else if (FetchEn) begin
            StepCount <= StepCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_step_ctrl.sv
// Directed bench for fetch_step_ctrl with short debounce and divide settings.

module tb_fetch_step_ctrl;

    logic       Clk;
    logic       Reset;
    logic       BtnStep;
    logic       SwRun;
    logic       FetchEn;
    logic       Running;
    logic [3:0] StepCount;

    int total;
    int bad;
    int cyc;
    int pulses;
    int first_at;
    int last_at;
    int c0;

    fetch_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RUN_DIV         (8),
        .CNT_W           (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .BtnStep   (BtnStep),
        .SwRun     (SwRun),
        .FetchEn   (FetchEn),
        .Running   (Running),
        .StepCount (StepCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        pulses   = 0;
        first_at = -1;
        last_at  = -1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            cyc++;
            if (FetchEn === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = cyc;
                last_at = cyc;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset   = 1'b0;
        BtnStep = 1'b0;
        SwRun   = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        cyc   = 0;
        clear_mon();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        Reset   = 1'b0;
        BtnStep = 1'b0;
        SwRun   = 1'b0;
        clear_mon();
        #2;
        check("rst_fetch_en", 32'(FetchEn), 32'd0);
        check("rst_running", 32'(Running), 32'd0);
        check("rst_step_count", 32'(StepCount), 32'd0);

        // 1: async reset while running, on a pulse cycle
        do_reset();
        SwRun = 1'b1;
        tick(24);
        check("t1_pre_fetch_en", 32'(FetchEn), 32'd1);
        check("t1_pre_running", 32'(Running), 32'd1);
        check("t1_pre_step_count", 32'(StepCount), 32'd1);
        Reset = 1'b0;
        #1;
        check("t1_async_fetch_en", 32'(FetchEn), 32'd0);
        check("t1_async_running", 32'(Running), 32'd0);
        check("t1_async_step_count", 32'(StepCount), 32'd0);
        tick(2);
        Reset = 1'b1;
        cyc   = 0;
        clear_mon();
        tick(16);
        check("t1_rerun_first_pulse", 32'(first_at), 32'd16);

        // 2: bouncy button then held
        do_reset();
        for (int i = 0; i < 20; i++) begin
            BtnStep = ((i / 2) % 2) == 0;
            tick(1);
        end
        c0 = cyc;
        BtnStep = 1'b1;
        tick(30);
        check("t2_pulses", 32'(pulses), 32'd1);
        check("t2_pulse_edge", 32'(first_at - c0), 32'd8);
        check("t2_step_count", 32'(StepCount), 32'd1);

        // 3: hold, release, press again
        do_reset();
        BtnStep = 1'b1;
        tick(100);
        BtnStep = 1'b0;
        tick(20);
        BtnStep = 1'b1;
        tick(30);
        check("t3_pulses", 32'(pulses), 32'd2);
        check("t3_first", 32'(first_at), 32'd8);
        check("t3_second", 32'(last_at), 32'd128);
        check("t3_step_count", 32'(StepCount), 32'd2);

        // 4: free-run, button presses ignored
        do_reset();
        SwRun = 1'b1;
        tick(7);
        check("t4_running_early", 32'(Running), 32'd0);
        tick(1);
        check("t4_running", 32'(Running), 32'd1);
        clear_mon();
        tick(5);
        BtnStep = 1'b1;
        tick(20);
        BtnStep = 1'b0;
        tick(15);
        check("t4_pulses", 32'(pulses), 32'd5);
        check("t4_first", 32'(first_at), 32'd16);
        check("t4_last", 32'(last_at), 32'd48);
        tick(2);
        check("t4_step_count", 32'(StepCount), 32'd5);

        // 5: 17 single steps, counter wraps
        do_reset();
        for (int s = 1; s <= 17; s++) begin
            BtnStep = 1'b1;
            tick(12);
            BtnStep = 1'b0;
            tick(10);
            if (s == 15) check("t5_count_15", 32'(StepCount), 32'd15);
            if (s == 16) check("t5_count_wrap", 32'(StepCount), 32'd0);
        end
        check("t5_pulses", 32'(pulses), 32'd17);
        check("t5_step_count", 32'(StepCount), 32'd1);

        // 6: leave run mid-period, re-enter, then leave on a deadline
        do_reset();
        SwRun = 1'b1;
        tick(12);
        SwRun = 1'b0;
        tick(4);
        check("t6_pulse_16", 32'(FetchEn), 32'd1);
        clear_mon();
        tick(3);
        check("t6_still_running", 32'(Running), 32'd1);
        tick(1);
        check("t6_halted", 32'(Running), 32'd0);
        tick(10);
        check("t6_no_old_deadline", 32'(pulses), 32'd0);
        SwRun = 1'b1;
        tick(8);
        check("t6_reentry", 32'(Running), 32'd1);
        clear_mon();
        tick(8);
        check("t6_new_pulses", 32'(pulses), 32'd1);
        check("t6_new_first", 32'(first_at), 32'd46);
        SwRun = 1'b0;
        clear_mon();
        tick(7);
        check("t6_run_before_exit", 32'(Running), 32'd1);
        tick(1);
        check("t6_exit", 32'(Running), 32'd0);
        tick(6);
        check("t6_suppressed", 32'(pulses), 32'd0);
        check("t6_step_count", 32'(StepCount), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
